// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the single-port memory arbiter.
// State, grant and counter definitions used by mem_arbiter and mem_wait_counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int CNT_W               = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; times the memory access window.
module mem_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between instruction fetch and data memory.
// Optional MEM_ARB_RR_EN: round-robin between IF and DM instead of DM-first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_grant;
    logic              r_is_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_dm_req;
    logic w_any_req;
    logic w_start;
    logic w_done;
    logic w_cnt_zero;
    logic w_grant_sel;

    assign w_dm_req  = dm_rd | dm_wr;
    assign w_any_req = if_req | w_dm_req;
    assign w_start   = (r_state == IDLE) && w_any_req;
    assign w_done    = (r_state == ACCESS) && w_cnt_zero;

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    // On contention the port that was not served last wins.
    always_comb begin
        w_grant_sel = GRANT_IF;
        if (w_dm_req && if_req) begin
            w_grant_sel = ~r_last_grant;
        end else if (w_dm_req) begin
            w_grant_sel = GRANT_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_IF;
        end else if (w_start) begin
            r_last_grant <= w_grant_sel;
        end
    end
`else
    // DM always wins on contention; a continuously requesting DM starves IF.
    assign w_grant_sel = w_dm_req ? GRANT_DM : GRANT_IF;
`endif

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start),
        .i_load_val (LOAD_VAL),
        .i_dec      ((r_state == ACCESS) && !w_cnt_zero),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= GRANT_IF;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_grant    <= w_grant_sel;
                r_is_write <= (w_grant_sel == GRANT_DM) && dm_wr;
            end
        end
    end

    // Operands are frozen at grant so requester changes during ACCESS are ignored.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_addr  <= (w_grant_sel == GRANT_DM) ? dm_addr : if_addr;
            r_wdata <= dm_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_done && !r_is_write) begin
            if (r_grant == GRANT_IF) begin
                r_if_rdata <= mem_rdata;
            end else begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ACCESS;
            ACCESS:  if (w_cnt_zero) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The write strobe is masked by rst so an aborted write never reaches memory.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if_ready  = 1'b0;
        dm_ready  = 1'b0;
        case (r_state)
            ACCESS: begin
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                mem_read  = !r_is_write;
                mem_write = r_is_write && w_cnt_zero && !rst;
            end
            RESP: begin
                if_ready = (r_grant == GRANT_IF);
                dm_ready = (r_grant == GRANT_DM);
            end
            default: ;
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: WAIT_CYCLES=2 main instance, WAIT_CYCLES=1 second instance.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    logic        if_req, dm_rd, dm_wr;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_read, mem_write, busy;

    logic        b_if_req, b_dm_rd, b_dm_wr;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_ready, b_dm_ready, b_mem_read, b_mem_write, b_busy;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  kind;   // 0 IF read, 1 DM read, 2 DM write, 3 DM rd+wr
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
    } vec_t;

    typedef struct {
        logic        port;   // 0 IF, 1 DM
        logic [31:0] data;
    } exp_t;

    vec_t vecs [8];
    exp_t sb_q [$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .dm_rd(b_dm_rd), .dm_wr(b_dm_wr), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: reset reloads the contents, combinational read, write on the edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem0[i] <= 32'h100 + i;
                mem1[i] <= 32'h200 + i;
            end
            mem0[4] <= 32'h0000_1234;
        end else begin
            if (mem_write) mem0[mem_addr[3:0]] <= mem_wdata;
            if (b_mem_write) mem1[b_mem_addr[3:0]] <= b_mem_wdata;
        end
    end
    assign mem_rdata   = mem0[mem_addr[3:0]];
    assign b_mem_rdata = mem1[b_mem_addr[3:0]];

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_if"}, {31'd0, if_ready, if_rdata}, 64'd0);
        chk({tag, "_dm"}, {31'd0, dm_ready, dm_rdata}, 64'd0);
        chk({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
        chk({tag, "_ctl"}, {61'd0, mem_read, mem_write, busy}, 64'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e, g;
        int   rd_cyc, wr_cyc, wr_at, rdy_at;
        logic got, rdy_port;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        case (v.kind)
            2'd0: begin if_req = 1'b1; if_addr = v.addr; end
            2'd1: begin dm_rd = 1'b1; dm_addr = v.addr; end
            2'd2: begin dm_wr = 1'b1; dm_addr = v.addr; dm_wdata = v.wdata; end
            default: begin dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = v.addr; dm_wdata = v.wdata; end
        endcase
        e.port = (v.kind != 2'd0);
        e.data = (v.kind == 2'd0) ? v.exp_if : v.exp_dm;
        sb_q.push_back(e);
        rd_cyc = 0; wr_cyc = 0; wr_at = 0; rdy_at = 0; got = 1'b0; rdy_port = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, v.addr});
            if (mem_read) rd_cyc++;
            if (mem_write) begin wr_cyc++; wr_at = c; end
            if (if_ready || dm_ready) begin
                got = 1'b1; rdy_at = c; rdy_port = dm_ready;
                chk({tag, "_single_ready"}, {62'd0, if_ready, dm_ready}, e.port ? 64'd1 : 64'd2);
                if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
            end
        end
        if (!got) begin
            chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
            sb_q.delete();
        end else begin
            g = sb_q.pop_front();
            chk({tag, "_latency"}, rdy_at, 64'd3);
            chk({tag, "_port"}, {63'd0, rdy_port}, {63'd0, g.port});
            chk({tag, "_rdata"}, {32'd0, g.port ? dm_rdata : if_rdata}, {32'd0, g.data});
            chk({tag, "_read_cycles"}, rd_cyc, (v.kind < 2) ? 64'd2 : 64'd0);
            chk({tag, "_write_cycles"}, wr_cyc, (v.kind >= 2) ? 64'd1 : 64'd0);
            if (v.kind >= 2) chk({tag, "_write_at"}, wr_at, 64'd2);
            chk({tag, "_if_rdata"}, {32'd0, if_rdata}, {32'd0, v.exp_if});
            chk({tag, "_dm_rdata"}, {32'd0, dm_rdata}, {32'd0, v.exp_dm});
        end
        @(negedge clk);
        chk({tag, "_after"}, {61'd0, busy, if_ready, dm_ready}, 64'd0);
    endtask

    initial begin
        exp_t g;
        int dm_at, if_at, idle_at, n_if, n_dm, alt_bad, bad_cnt;
        logic have_last, last_port;

        vecs[0] = '{2'd0, 32'd4, 32'd0,          32'h0000_1234, 32'h0};
        vecs[1] = '{2'd2, 32'd7, 32'hDEAD_BEEF,  32'h0000_1234, 32'h0};
        vecs[2] = '{2'd1, 32'd7, 32'd0,          32'h0000_1234, 32'hDEAD_BEEF};
        vecs[3] = '{2'd2, 32'd3, 32'hCAFE_F00D,  32'h0000_1234, 32'hDEAD_BEEF};
        vecs[4] = '{2'd0, 32'd3, 32'd0,          32'hCAFE_F00D, 32'hDEAD_BEEF};
        vecs[5] = '{2'd3, 32'd5, 32'h0000_55AA,  32'hCAFE_F00D, 32'hDEAD_BEEF};
        vecs[6] = '{2'd1, 32'd5, 32'd0,          32'hCAFE_F00D, 32'h0000_55AA};
        vecs[7] = '{2'd0, 32'd7, 32'd0,          32'hDEAD_BEEF, 32'h0000_55AA};

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_dm_rd = 1'b0; b_dm_wr = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");
        chk("reset_dut1", {29'd0, b_busy, b_if_ready, b_dm_ready, b_if_rdata}, 64'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Contention: DM first, IF served after the intervening IDLE cycle.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'd0; dm_rd = 1'b1; dm_addr = 32'd9;
        sb_q.push_back('{1'b1, 32'h0000_0109});
        sb_q.push_back('{1'b0, 32'h0000_0100});
        dm_at = 0; if_at = 0; idle_at = 0;
        for (int c = 1; c <= 20 && idle_at == 0; c++) begin
            @(negedge clk);
            if (dm_ready) begin
                dm_at = c; g = sb_q.pop_front();
                chk("both_dm_port", {63'd0, g.port}, 64'd1);
                chk("both_dm_rdata", {32'd0, dm_rdata}, {32'd0, g.data});
                dm_rd = 1'b0;
            end
            if (if_ready) begin
                if_at = c; g = sb_q.pop_front();
                chk("both_if_port", {63'd0, g.port}, 64'd0);
                chk("both_if_rdata", {32'd0, if_rdata}, {32'd0, g.data});
                if_req = 1'b0;
            end
            if (if_at != 0 && c > if_at && !busy) idle_at = c;
        end
        chk("both_dm_ready_cycle", dm_at, 64'd3);
        chk("both_if_ready_cycle", if_at, 64'd7);
        chk("both_busy_drop_cycle", idle_at, 64'd8);
        sb_q.delete();

        // Both requesters held for 24 cycles.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'd1; dm_rd = 1'b1; dm_addr = 32'd2;
        n_if = 0; n_dm = 0; alt_bad = 0; have_last = 1'b0; last_port = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (if_ready || dm_ready) begin
                if (!have_last && !dm_ready) alt_bad++;
                if (have_last && (last_port == dm_ready)) alt_bad++;
                have_last = 1'b1; last_port = dm_ready;
                if (if_ready) n_if++;
                if (dm_ready) n_dm++;
            end
        end
        if_req = 1'b0; dm_rd = 1'b0;
`ifdef MEM_ARB_RR_EN
        chk("rr_if_grants", n_if, 64'd3);
        chk("rr_dm_grants", n_dm, 64'd3);
        chk("rr_alternation_errors", alt_bad, 64'd0);
`else
        chk("fixed_if_starved", n_if, 64'd0);
        chk("fixed_dm_grants", n_dm, 64'd6);
`endif
        @(negedge clk);
        chk("hold_end_idle", {63'd0, busy}, 64'd0);

        // Reset during the first ACCESS cycle of a write aborts it.
        chk("pre_abort_dm_rdata_nonzero", {63'd0, dm_rdata != 32'd0}, 64'd1);
        dm_wr = 1'b1; dm_addr = 32'd6; dm_wdata = 32'h0000_0077;
        @(negedge clk);
        chk("abort_in_access", {63'd0, busy}, 64'd1);
        rst = 1'b1; dm_wr = 1'b0;
        #1;
        chk("abort_no_write_in_rst_cycle", {63'd0, mem_write}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("abort");
        bad_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_write || if_ready || dm_ready || busy) bad_cnt++;
        end
        chk("abort_quiet_after", bad_cnt, 64'd0);

        // WAIT_CYCLES=1: back-to-back IF reads of addresses 0,1,2.
        @(negedge clk);
        b_if_req = 1'b1; b_if_addr = 32'd0;
        for (int k = 0; k < 3; k++) sb_q.push_back('{1'b0, 32'h200 + k});
        begin
            int nrdy;
            nrdy = 0;
            for (int c = 1; c <= 20 && nrdy < 3; c++) begin
                @(negedge clk);
                if (b_if_ready) begin
                    g = sb_q.pop_front();
                    chk($sformatf("w1_ready_cycle%0d", nrdy), c, 2 + 3 * nrdy);
                    chk($sformatf("w1_rdata%0d", nrdy), {32'd0, b_if_rdata}, {32'd0, g.data});
                    nrdy++;
                    b_if_addr = nrdy;
                    if (nrdy == 3) b_if_req = 1'b0;
                end
            end
            chk("w1_ready_count", nrdy, 64'd3);
        end
        b_if_req = 1'b0;
        @(negedge clk);
        chk("w1_idle_after", {62'd0, b_busy, b_dm_ready}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
